// File: rtl/sevenseg_pkg.sv
// Shared definitions for the iomem seven-segment / switch / button peripheral:
// register offsets, CTRL field positions and the hex digit font.
package sevenseg_pkg;

    // Word offsets within the peripheral, taken from iomem_addr[3:2]
    typedef enum logic [1:0] {
        REG_DATA  = 2'd0,
        REG_CTRL  = 2'd1,
        REG_INPUT = 2'd2,
        REG_EDGE  = 2'd3
    } regSel_e;

    // CTRL field layout
    localparam int          CTRL_EN_BIT    = 0;
    localparam int          CTRL_DP_LSB    = 4;
    localparam int          CTRL_BLANK_LSB = 8;
    localparam int          CTRL_WIDTH     = 12;
    localparam logic [11:0] CTRL_RW_MASK   = 12'hFF1;

    // Number of debounced buttons {C,U,L,R,D}
    localparam int          NUM_BTN        = 5;

    // Active-low cathode patterns {g,f,e,d,c,b,a}, indexed by nibble value.
    // The list runs from F down to 0 so that HEX_FONT[n] is the glyph for n.
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    // Expand the two low byte strobes into a 16-bit write mask
    function automatic logic [15:0] byteMask16(input logic [1:0] strb);
        return {{8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// N-bit button conditioner: two-flop synchronizer, slow shared sample tick,
// two-sample agreement filter and a rising-edge pulse aligned with the level.
module btn_debounce #(
    parameter int N   = 5,
    parameter int DIV = 100000
) (
    input  logic         CLKOUT,
    input  logic         resetn,
    input  logic [N-1:0] i_raw,
    output logic [N-1:0] o_level,
    output logic [N-1:0] o_rise
);

    localparam int              TICK_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);

    logic [N-1:0]      r_meta;
    logic [N-1:0]      r_sync;
    logic [N-1:0]      r_prev;
    logic [N-1:0]      r_level;
    logic [TICK_W-1:0] r_tickCnt;

    logic              w_tick;
    logic [N-1:0]      w_stable;
    logic [N-1:0]      w_levelNext;

    assign w_tick      = (r_tickCnt == TICK_LAST);
    assign w_stable    = ~(r_prev ^ r_sync);
    assign w_levelNext = w_tick ? ((r_level & ~w_stable) | (r_sync & w_stable)) : r_level;

    assign o_level     = r_level;
    // Combinational so the caller can register its sticky flag on the same edge the level rises
    assign o_rise      = w_levelNext & ~r_level;

    // Bring the asynchronous buttons into the CLKOUT domain
    always_ff @(posedge CLKOUT) begin
        if (!resetn) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    // Free-running divider producing one sample tick every DIV cycles
    always_ff @(posedge CLKOUT) begin
        if (!resetn) begin
            r_tickCnt <= '0;
        end else if (w_tick) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + TICK_W'(1);
        end
    end

    // On each tick, accept a bit only when two consecutive samples agree
    always_ff @(posedge CLKOUT) begin
        if (!resetn) begin
            r_prev  <= '0;
            r_level <= '0;
        end else begin
            if (w_tick) begin
                r_prev <= r_sync;
            end
            r_level <= w_levelNext;
        end
    end

endmodule

// File: rtl/iomem_sevenseg.sv
// iomem-bus peripheral: 4-digit multiplexed hex display, synchronized switch
// readback, debounced buttons and sticky W1C button-press flags.
module iomem_sevenseg #(
    parameter logic [7:0] BASE_ADDR    = 8'h04,
    parameter int         REFRESH_DIV  = 10000,
    parameter int         DEBOUNCE_DIV = 100000
) (
    input  logic        CLKOUT,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    input  logic [15:0] sw,
    input  logic [4:0]  btn,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    import sevenseg_pkg::*;

    localparam int                   REFRESH_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_DIV - 1);

    logic [15:0]           r_swMeta;
    logic [15:0]           r_swSync;
    logic [15:0]           r_data;
    logic [CTRL_WIDTH-1:0] r_ctrl;
    logic [NUM_BTN-1:0]    r_edge;
    logic [REFRESH_W-1:0]  r_refreshCnt;
    logic [1:0]            r_digitIdx;

    logic [NUM_BTN-1:0]    w_btnLevel;
    logic [NUM_BTN-1:0]    w_btnRise;
    logic                  w_access;
    logic                  w_write;
    regSel_e               w_sel;
    logic [15:0]           w_mask16;
    logic [31:0]           w_readData;
    logic [NUM_BTN-1:0]    w_edgeClr;
    logic [3:0]            w_nibble;
    logic [3:0]            w_dpMask;
    logic [3:0]            w_blankMask;
    logic                  w_digitOn;
    logic [37:0]           w_unusedBits;

    // Address bits [23:4] and [1:0] are don't-care (the map aliases); upper write data has no home
    assign w_unusedBits = {iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:16]};

    // A new access starts only while ready is low, so ready can never stretch past one cycle
    assign w_access  = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
    assign w_write   = w_access && (iomem_wstrb != 4'h0);
    assign w_sel     = regSel_e'(iomem_addr[3:2]);
    assign w_mask16  = byteMask16(iomem_wstrb[1:0]);
    assign w_edgeClr = (w_access && (w_sel == REG_EDGE) && iomem_wstrb[0])
                       ? iomem_wdata[NUM_BTN-1:0] : '0;

    // Button conditioning for {C,U,L,R,D}
    btn_debounce #(
        .N   (NUM_BTN),
        .DIV (DEBOUNCE_DIV)
    ) u_btnDebounce (
        .CLKOUT  (CLKOUT),
        .resetn  (resetn),
        .i_raw   (btn),
        .o_level (w_btnLevel),
        .o_rise  (w_btnRise)
    );

    // Two-flop synchronizer for the slide switches
    always_ff @(posedge CLKOUT) begin
        if (!resetn) begin
            r_swMeta <= '0;
            r_swSync <= '0;
        end else begin
            r_swMeta <= sw;
            r_swSync <= r_swMeta;
        end
    end

    // Read mux; sampled into rdata before any same-cycle write lands
    always_comb begin
        w_readData = '0;
        case (w_sel)
            REG_DATA:  w_readData = {16'h0, r_data};
            REG_CTRL:  w_readData = {20'h0, r_ctrl};
            REG_INPUT: w_readData = {11'h0, w_btnLevel, r_swSync};
            REG_EDGE:  w_readData = {27'h0, r_edge};
        endcase
    end

    // Bus handshake plus byte-strobed DATA and CTRL writes
    always_ff @(posedge CLKOUT) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            r_data      <= '0;
            r_ctrl      <= '0;
        end else begin
            iomem_ready <= w_access;
            if (w_access) begin
                iomem_rdata <= w_readData;
            end
            if (w_write && (w_sel == REG_DATA)) begin
                r_data <= (r_data & ~w_mask16) | (iomem_wdata[15:0] & w_mask16);
            end
            if (w_write && (w_sel == REG_CTRL)) begin
                r_ctrl <= ((r_ctrl & ~w_mask16[CTRL_WIDTH-1:0])
                          | (iomem_wdata[CTRL_WIDTH-1:0] & w_mask16[CTRL_WIDTH-1:0]))
                          & CTRL_RW_MASK;
            end
        end
    end

    // Sticky press flags; a new press in the same cycle as a clear keeps the flag set
    always_ff @(posedge CLKOUT) begin
        if (!resetn) begin
            r_edge <= '0;
        end else begin
            r_edge <= (r_edge & ~w_edgeClr) | w_btnRise;
        end
    end

    // Slot timer: each digit owns REFRESH_DIV cycles, then the scan moves one digit left
    always_ff @(posedge CLKOUT) begin
        if (!resetn) begin
            r_refreshCnt <= '0;
            r_digitIdx   <= 2'd0;
        end else if (r_refreshCnt == REFRESH_LAST) begin
            r_refreshCnt <= '0;
            r_digitIdx   <= r_digitIdx + 2'd1;
        end else begin
            r_refreshCnt <= r_refreshCnt + REFRESH_W'(1);
        end
    end

    assign w_nibble    = r_data[{r_digitIdx, 2'b00} +: 4];
    assign w_dpMask    = r_ctrl[CTRL_DP_LSB +: 4];
    assign w_blankMask = r_ctrl[CTRL_BLANK_LSB +: 4];
    assign w_digitOn   = r_ctrl[CTRL_EN_BIT] && !w_blankMask[r_digitIdx];

    // Registered display drive for the currently scanned digit
    always_ff @(posedge CLKOUT) begin
        if (!resetn) begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= w_digitOn ? ~(4'b0001 << r_digitIdx) : 4'hF;
            seg <= HEX_FONT[w_nibble];
            dp  <= ~w_dpMask[r_digitIdx];
        end
    end

endmodule

// File: tb/tb_iomem_sevenseg.sv
// Self-checking bench for iomem_sevenseg: randomized bus traffic, switch and
// button patterns, compared against a register-level model of the peripheral.
module tb_iomem_sevenseg;

    localparam logic [7:0] BASE   = 8'h04;
    localparam int         RD     = 8;
    localparam int         DD     = 64;
    localparam int         SETTLE = 3 * DD + 4;

    logic        CLKOUT      = 1'b0;
    logic        resetn      = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr  = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic [15:0] sw          = 16'h0;
    logic [4:0]  btn         = 5'h0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int compareCount  = 0;
    int mismatchCount = 0;
    int edgeCount     = 0;

    // Register-level model of what software should see
    logic [15:0] mData = 16'h0;
    logic [11:0] mCtrl = 12'h0;
    logic [4:0]  mEdge = 5'h0;
    logic [4:0]  mBtn  = 5'h0;

    always #5 CLKOUT = ~CLKOUT;

    iomem_sevenseg #(
        .BASE_ADDR    (BASE),
        .REFRESH_DIV  (RD),
        .DEBOUNCE_DIV (DD)
    ) dut (
        .CLKOUT      (CLKOUT),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .sw          (sw),
        .btn         (btn),
        .seg         (seg),
        .dp          (dp),
        .an          (an)
    );

    // Clock edges seen out of reset; the scan position follows from this alone
    always @(posedge CLKOUT) begin
        if (!resetn) edgeCount <= 0;
        else         edgeCount <= edgeCount + 1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, actual, expected);
        end
    endtask

    // Glyph from the list of lit segments, active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] fontOf(input logic [3:0] n);
        string      lit;
        logic [6:0] code;
        int         k;
        code = 7'h7F;
        case (n)
            4'h0: lit = "abcdef";
            4'h1: lit = "bc";
            4'h2: lit = "abdeg";
            4'h3: lit = "abcdg";
            4'h4: lit = "bcfg";
            4'h5: lit = "acdfg";
            4'h6: lit = "acdefg";
            4'h7: lit = "abc";
            4'h8: lit = "abcdefg";
            4'h9: lit = "abcdfg";
            4'hA: lit = "abcefg";
            4'hB: lit = "cdefg";
            4'hC: lit = "adef";
            4'hD: lit = "bcdeg";
            4'hE: lit = "adefg";
            default: lit = "aefg";
        endcase
        for (int i = 0; i < lit.len(); i++) begin
            k = lit[i] - 97;
            code[k] = 1'b0;
        end
        return code;
    endfunction

    // One bus transaction with a bounded wait for ready
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                                 output logic [31:0] rdata, output bit gotReady);
        @(negedge CLKOUT);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wdata = wdata;
        iomem_wstrb = strb;
        gotReady    = 1'b0;
        rdata       = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLKOUT);
            #1;
            if (iomem_ready) begin
                gotReady = 1'b1;
                rdata    = iomem_rdata;
                break;
            end
        end
        @(negedge CLKOUT);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    // Register access checked against the model, which is then updated
    task automatic busOp(input string tag, input logic [1:0] sel, input logic [31:0] wdata, input logic [3:0] strb);
        logic [31:0] addr;
        logic [31:0] expRd;
        logic [31:0] rd;
        logic [31:0] m;
        logic [19:0] junkHi;
        logic [1:0]  junkLo;
        bit          got;
        junkHi = 20'($urandom);
        junkLo = 2'($urandom);
        addr   = {BASE, junkHi, sel, junkLo};
        case (sel)
            2'd0:    expRd = {16'h0, mData};
            2'd1:    expRd = {20'h0, mCtrl};
            2'd2:    expRd = {11'h0, mBtn, sw};
            default: expRd = {27'h0, mEdge};
        endcase
        applyStimulus(addr, wdata, strb, rd, got);
        checkOutput({tag, ".ack"}, 32'(got), 32'd1);
        checkOutput({tag, ".rdata"}, rd, expRd);
        @(negedge CLKOUT);
        checkOutput({tag, ".rdyLow"}, 32'(iomem_ready), 32'd0);
        if (strb != 4'h0) begin
            m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
            case (sel)
                2'd0: mData = (mData & ~m[15:0]) | (wdata[15:0] & m[15:0]);
                2'd1: mCtrl = ((mCtrl & ~m[11:0]) | (wdata[11:0] & m[11:0])) & 12'hFF1;
                2'd3: if (strb[0]) mEdge = mEdge & ~wdata[4:0];
                default: ;
            endcase
        end
    endtask

    // Compare the display against the expected scan position every cycle
    task automatic scanCheck(input string tag, input int cycles);
        int         idx;
        logic [3:0] nib;
        logic [3:0] expAn;
        logic       expDp;
        for (int c = 0; c < cycles; c++) begin
            @(negedge CLKOUT);
            idx   = ((edgeCount - 1) / RD) % 4;
            nib   = mData[idx*4 +: 4];
            expAn = (mCtrl[0] && !mCtrl[8+idx]) ? ~(4'b0001 << idx) : 4'hF;
            expDp = !mCtrl[4+idx];
            checkOutput({tag, ".an"}, 32'(an), 32'(expAn));
            checkOutput({tag, ".seg"}, 32'(seg), 32'(fontOf(nib)));
            checkOutput({tag, ".dp"}, 32'(dp), 32'(expDp));
        end
    endtask

    // Hold a button pattern long enough to be accepted, then account for it
    task automatic holdButtons(input logic [4:0] pat);
        @(negedge CLKOUT);
        btn = pat;
        repeat (SETTLE) @(negedge CLKOUT);
        mEdge = mEdge | (pat & ~mBtn);
        mBtn  = pat;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [1:0]  sel;
        bit          got;

        $display("[TB] start");
        resetn = 1'b0;
        repeat (4) @(negedge CLKOUT);
        checkOutput("reset.an",    32'(an), 32'hF);
        checkOutput("reset.seg",   32'(seg), 32'h7F);
        checkOutput("reset.dp",    32'(dp), 32'h1);
        checkOutput("reset.ready", 32'(iomem_ready), 32'h0);
        checkOutput("reset.rdata", iomem_rdata, 32'h0);
        @(negedge CLKOUT);
        resetn = 1'b1;

        busOp("rst.data",  2'd0, 32'h0, 4'h0);
        busOp("rst.ctrl",  2'd1, 32'h0, 4'h0);
        busOp("rst.input", 2'd2, 32'h0, 4'h0);
        busOp("rst.edge",  2'd3, 32'h0, 4'h0);

        // Directed BEEF display walk
        busOp("beef.data", 2'd0, 32'h0000BEEF, 4'hF);
        busOp("beef.ctrl", 2'd1, 32'h00000001, 4'hF);
        scanCheck("beef", 4 * RD + 4);

        // Switch readback; the write to INPUT must be ignored
        sw = 16'hA5A5;
        repeat (3) @(negedge CLKOUT);
        busOp("input.w", 2'd2, 32'hFFFFFFFF, 4'hF);
        busOp("input.r", 2'd2, 32'h0, 4'h0);

        // Only byte 1 of CTRL written: blank all digits, enable stays set
        busOp("strb.ctrl", 2'd1, 32'h00000F00, 4'b0010);
        busOp("strb.read", 2'd1, 32'h0, 4'h0);
        scanCheck("blank", 2 * RD);

        // Bouncing centre-right button settles to one press
        for (int i = 0; i < 50; i++) begin
            @(negedge CLKOUT);
            if (i % 3 == 0) btn[0] = ~btn[0];
        end
        holdButtons(5'b00001);
        busOp("bounce.input", 2'd2, 32'h0, 4'h0);
        busOp("bounce.edge",  2'd3, 32'h0, 4'h0);
        busOp("bounce.clr",   2'd3, 32'h1, 4'h1);
        busOp("bounce.zero",  2'd3, 32'h0, 4'h0);
        repeat (SETTLE) @(negedge CLKOUT);
        busOp("bounce.once",  2'd3, 32'h0, 4'h0);

        // Random button patterns with random flag clears
        for (int n = 0; n < 5; n++) begin
            holdButtons(5'($urandom));
            busOp("rbtn.input", 2'd2, 32'h0, 4'h0);
            wd = $urandom;
            st = 4'($urandom);
            busOp("rbtn.edge", 2'd3, wd, st);
            busOp("rbtn.after", 2'd3, 32'h0, 4'h0);
        end

        // Random register traffic with changing switches
        for (int n = 0; n < 40; n++) begin
            sw = 16'($urandom);
            repeat (3) @(negedge CLKOUT);
            sel = 2'($urandom);
            wd  = $urandom;
            st  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            busOp("rand", sel, wd, st);
        end

        // Random display contents and masks
        for (int n = 0; n < 3; n++) begin
            busOp("rscan.data", 2'd0, $urandom, 4'hF);
            wd = $urandom;
            if (n < 2) wd[0] = 1'b1;
            busOp("rscan.ctrl", 2'd1, wd, 4'hF);
            scanCheck("rscan", 4 * RD + 2);
        end

        // Foreign address: no acknowledge, no side effect
        applyStimulus({BASE ^ 8'h5A, 24'h000000}, 32'h00001234, 4'hF, rd, got);
        checkOutput("noMatch.ready", 32'(got), 32'h0);
        busOp("noMatch.data", 2'd0, 32'h0, 4'h0);

        // Reset landing on a write: the write is dropped, everything clears
        busOp("preRst.data", 2'd0, 32'h00005A5A, 4'hF);
        holdButtons(5'b00000);
        @(negedge CLKOUT);
        iomem_valid = 1'b1;
        iomem_addr  = {BASE, 24'h000000};
        iomem_wdata = 32'h0000C0DE;
        iomem_wstrb = 4'hF;
        resetn      = 1'b0;
        @(posedge CLKOUT);
        #1;
        checkOutput("rstMid.ready", 32'(iomem_ready), 32'h0);
        @(negedge CLKOUT);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        @(negedge CLKOUT);
        resetn = 1'b1;
        mData = 16'h0;
        mCtrl = 12'h0;
        mEdge = 5'h0;
        mBtn  = 5'h0;
        busOp("rstMid.data", 2'd0, 32'h0, 4'h0);
        busOp("rstMid.ctrl", 2'd1, 32'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/iomem_sevenseg.md
# iomem_sevenseg

Memory-mapped peripheral on the picoramsoc `iomem` bus, decoded at `iomem_addr[31:24] == BASE_ADDR`. It sits beside the LED GPIO register on the Basys3 top level. It drives the 4-digit multiplexed 7-segment display and makes switches and buttons readable, with button debouncing and sticky press flags. Register access uses the same one-cycle `iomem_valid`/`iomem_ready` handshake as the GPIO register.

## Interface
Parameters:
- `BASE_ADDR`, default 8'h04: value of `iomem_addr[31:24]` that selects this block.
- `REFRESH_DIV`, default 10000: CLKOUT cycles per digit slot. At 10 MHz this gives 1 kHz slot rate and 250 Hz per digit.
- `DEBOUNCE_DIV`, default 100000: CLKOUT cycles between button samples (10 ms at 10 MHz).

Ports:
- `CLKOUT`, in, 1: system clock.
- `resetn`, in, 1: reset, synchronous, active-low.
- `iomem_valid`, in, 1: bus request.
- `iomem_ready`, out, 1: one-cycle acknowledge.
- `iomem_wstrb`, in, 4: byte write strobes; 0 means read.
- `iomem_addr`, in, 32: bus address.
- `iomem_wdata`, in, 32: write data.
- `iomem_rdata`, out, 32: registered read data.
- `sw`, in, 16: raw slide switches, asynchronous.
- `btn`, in, 5: raw buttons {C,U,L,R,D}, asynchronous.
- `seg`, out, 7: segment cathodes {g,f,e,d,c,b,a}, active-low.
- `dp`, out, 1: decimal point, active-low.
- `an`, out, 4: digit anodes, active-low; `an[0]` is the rightmost digit.

## Operation
Register map, selected by `iomem_addr[3:2]`; address bits [23:4] are ignored, so the map aliases.
- 0x0 DATA (R/W): bits [15:0] hold four hex nibbles; digit *i* shows `DATA[4i+3:4i]`. Bits [31:16] read 0.
- 0x4 CTRL (R/W):
  - bit 0: enable.
  - bits [7:4]: per-digit decimal-point mask.
  - bits [11:8]: per-digit blank mask.
  - Other bits read 0.
- 0x8 INPUT (RO): bits [15:0] = synchronized `sw`; bits [20:16] = debounced `btn`. Writes are ignored but still acknowledged.
- 0xC EDGE (R/W1C): bits [4:0] are sticky flags, set on a debounced 0→1 button transition. Writing 1 to a bit clears it.

Byte strobes apply per byte to DATA and CTRL. An EDGE clear requires `wstrb[0]`.

Bus behaviour:
- An access starts when `iomem_valid && !iomem_ready` and the address matches.
- Non-matching addresses get no response: `iomem_ready` stays 0.

Input conditioning:
- `sw` and `btn` each pass through a 2-FF synchronizer.
- A shared tick fires once every DEBOUNCE_DIV cycles.
- On each tick, a button's debounced bit takes the synchronized value only if the previous sample equalled the current one.

Display scan:
- A refresh counter runs 0..REFRESH_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
- The active digit is lit, i.e. `an = ~(1<<idx)`, when CTRL.enable is set and the digit's blank bit is clear. Otherwise `an = 4'hF`.
- `seg` is the hex font of the active nibble, covering 0-9 and A-F (b, d lowercase). `dp = ~CTRL[4+idx]`.

## Timing
- Reset values:
  - DATA=0, CTRL=0, EDGE=0, debounced=0.
  - `iomem_ready`=0, `iomem_rdata`=0.
  - `an`=4'hF, `seg`=7'h7F, `dp`=1.
  - Counters and digit index = 0.
- Handshake:
  - `iomem_ready` rises the cycle after the matching valid is sampled, stays high exactly 1 cycle, then is low for at least 1 cycle.
  - Writes take effect on the same edge that raises `iomem_ready`.
  - `iomem_rdata` is valid while `iomem_ready` is high and returns the pre-write value.
- `seg`, `an` and `dp` are registered; a DATA or CTRL write is visible 1 cycle after ready.
- Press to debounced: 2 sync cycles plus 1-2 ticks. The EDGE flag sets the same cycle the debounced bit rises.
- If a flag set and a W1C clear hit the same bit in the same cycle, the set wins.
- Reset asserted mid-transaction: ready drops next edge, and the pending write is discarded.

## Structure
- Package `sevenseg_pkg` holds:
  - the register offsets (DATA, CTRL, INPUT, EDGE);
  - the 16-entry hex-to-segment font constant;
  - the CTRL field bit positions.
- One sub-module, `btn_debounce`: the synchronizer, tick comparison and rising-edge pulse for N bits, instanced with N=5.

## Test plan
- Write DATA=0x0000BEEF, CTRL=0x1 → across 4 slots, `an` = E,D,B,7 with `seg` showing F,E,E,B; each slot lasts REFRESH_DIV cycles.
- Read INPUT with sw=16'hA5A5 held → rdata=0x0000A5A5, with ready asserted for exactly 1 cycle.
- Bouncy btn[0] (toggle every 3 cycles for 50 cycles, then hold 1) → single debounced rise, EDGE=0x1. Write EDGE=0x1 → reads 0.
- Write CTRL with wstrb=4'b0010, wdata=0x00000F00 → all digits blanked (`an`=4'hF), enable bit unchanged.
- Access with addr[31:24]≠BASE_ADDR → `iomem_ready` never asserts. Assert `resetn`=0 mid-write → DATA stays 0.
